// File: rtl/mem_ss_cal_monitor.sv
// Per-channel EMIF calibration monitor: synchronizes cal-done levels and tracks WAIT/PASS/FAIL/LOST.
// Define MEM_SS_CAL_LOSS_CNT_EN to build the per-channel saturating loss counters.
module mem_ss_cal_monitor #(
    parameter int unsigned NUM_CHANNELS   = 2,
    parameter int unsigned SYNC_STAGES    = 3,
    parameter int unsigned TIMEOUT_W      = 24,
    parameter int unsigned TIMEOUT_CYCLES = 10000000,
    parameter int unsigned LOSS_CNT_W     = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CHANNELS-1:0]            cal_success_in,
    input  logic [NUM_CHANNELS-1:0]            rearm,
    output logic [NUM_CHANNELS-1:0]            cal_success,
    output logic [NUM_CHANNELS-1:0]            cal_fail,
    output logic                               all_cal_done,
    output logic                               any_cal_fail,
    output logic [NUM_CHANNELS*LOSS_CNT_W-1:0] loss_cnt
);

    typedef enum logic [1:0] {
        StWait = 2'd0,
        StPass = 2'd1,
        StFail = 2'd2,
        StLost = 2'd3
    } state_e;

    localparam bit                    TimeoutEn   = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_W-1:0]  TimeoutLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0]  TimerMax    = '1;

    logic [NUM_CHANNELS-1:0] sync_ok;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q;
        state_e                 state_q;
        logic [TIMEOUT_W-1:0]   timer_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], cal_success_in[c]};
            end
        end

        assign sync_ok[c] = sync_q[SYNC_STAGES-1];

        // rearm wins over every transition, including a same-cycle sync_ok change
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= StWait;
                timer_q <= '0;
            end else if (rearm[c]) begin
                state_q <= StWait;
                timer_q <= '0;
            end else begin
                case (state_q)
                    StWait: begin
                        if (sync_ok[c]) begin
                            state_q <= StPass;
                            timer_q <= '0;
                        end else if (TimeoutEn && (timer_q == TimeoutLast)) begin
                            state_q <= StFail;
                            timer_q <= '0;
                        end else if (timer_q != TimerMax) begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    StPass: begin
                        timer_q <= '0;
                        if (!sync_ok[c]) begin
                            state_q <= StLost;
                        end
                    end
                    StFail, StLost: begin
                        timer_q <= '0;
                        if (sync_ok[c]) begin
                            state_q <= StPass;
                        end
                    end
                    default: begin
                        state_q <= StWait;
                        timer_q <= '0;
                    end
                endcase
            end
        end

        assign cal_success[c] = (state_q == StPass);
        assign cal_fail[c]    = (state_q == StFail) || (state_q == StLost);

`ifdef MEM_SS_CAL_LOSS_CNT_EN
        localparam logic [LOSS_CNT_W-1:0] LossMax = '1;
        logic [LOSS_CNT_W-1:0] loss_q;

        // Counts only PASS->LOST; recovery leaves the count alone
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                loss_q <= '0;
            end else if (rearm[c]) begin
                loss_q <= '0;
            end else if ((state_q == StPass) && !sync_ok[c] && (loss_q != LossMax)) begin
                loss_q <= loss_q + 1'b1;
            end
        end

        assign loss_cnt[c*LOSS_CNT_W +: LOSS_CNT_W] = loss_q;
`else
        assign loss_cnt[c*LOSS_CNT_W +: LOSS_CNT_W] = '0;
`endif
    end

    assign all_cal_done = &cal_success;
    assign any_cal_fail = |cal_fail;

endmodule

// File: tb/tb_mem_ss_cal_monitor.sv
// Scoreboard bench for mem_ss_cal_monitor: directed stimulus pushes expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_mem_ss_cal_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cal_in = 2'b00;
    logic [1:0]  rearm = 2'b00;
    logic [1:0]  cal_success;
    logic [1:0]  cal_fail;
    logic        all_cal_done;
    logic        any_cal_fail;
    logic [15:0] loss_cnt;

    typedef struct {
        string       name;
        logic [1:0]  succ;
        logic [1:0]  fail;
        logic        all_done;
        logic        any_fail;
        logic [15:0] loss;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    mem_ss_cal_monitor #(
        .NUM_CHANNELS  (2),
        .SYNC_STAGES   (3),
        .TIMEOUT_W     (24),
        .TIMEOUT_CYCLES(16),
        .LOSS_CNT_W    (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cal_success_in(cal_in),
        .rearm         (rearm),
        .cal_success   (cal_success),
        .cal_fail      (cal_fail),
        .all_cal_done  (all_cal_done),
        .any_cal_fail  (any_cal_fail),
        .loss_cnt      (loss_cnt)
    );

    always #5 clk = ~clk;

    // Loss counters only exist when the macro is defined; otherwise they read 0
    function automatic logic [15:0] lx(input logic [7:0] c1, input logic [7:0] c0);
`ifdef MEM_SS_CAL_LOSS_CNT_EN
        return {c1, c0};
`else
        return {c1, c0} & 16'h0000;
`endif
    endfunction

    task automatic expect_out(input string name, input logic [1:0] s, input logic [1:0] f,
                              input logic a, input logic y, input logic [15:0] l);
        exp_t e;
        e.name = name;
        e.succ = s;
        e.fail = f;
        e.all_done = a;
        e.any_fail = y;
        e.loss = l;
        sb_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic loss_event();
        cal_in[0] = 1'b0;
        step(2);
        cal_in[0] = 1'b1;
        step(2);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (cal_success !== e.succ || cal_fail !== e.fail ||
                    all_cal_done !== e.all_done || any_cal_fail !== e.any_fail ||
                    loss_cnt !== e.loss) begin
                    failures++;
                    $display("FAIL %s: got succ=%b fail=%b all=%b any=%b loss=%h, want succ=%b fail=%b all=%b any=%b loss=%h",
                             e.name, cal_success, cal_fail, all_cal_done, any_cal_fail, loss_cnt,
                             e.succ, e.fail, e.all_done, e.any_fail, e.loss);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    initial begin : stim
        reset = 1'b1;
        step(3);
        expect_out("reset_hold", 2'b00, 2'b00, 1'b0, 1'b0, lx(8'd0, 8'd0));
        cal_in = 2'b11;
        step(2);
        expect_out("reset_inputs_high", 2'b00, 2'b00, 1'b0, 1'b0, lx(8'd0, 8'd0));
        cal_in = 2'b00;
        step(1);
        reset = 1'b0;

        // ch0 raised after edge 5: PASS exactly four edges later
        step(5);
        cal_in[0] = 1'b1;
        step(3);
        expect_out("latency_edge8", 2'b00, 2'b00, 1'b0, 1'b0, lx(8'd0, 8'd0));
        step(1);
        expect_out("pass_edge9", 2'b01, 2'b00, 1'b0, 1'b0, lx(8'd0, 8'd0));
        step(6);
        expect_out("no_timeout_edge15", 2'b01, 2'b00, 1'b0, 1'b0, lx(8'd0, 8'd0));
        step(1);
        expect_out("timeout_edge16", 2'b01, 2'b10, 1'b0, 1'b1, lx(8'd0, 8'd0));

        cal_in[1] = 1'b1;
        step(3);
        expect_out("late_pending", 2'b01, 2'b10, 1'b0, 1'b1, lx(8'd0, 8'd0));
        step(1);
        expect_out("late_pass", 2'b11, 2'b00, 1'b1, 1'b0, lx(8'd0, 8'd0));

        // ch0 low for 10 cycles
        cal_in[0] = 1'b0;
        step(3);
        expect_out("loss_latency", 2'b11, 2'b00, 1'b1, 1'b0, lx(8'd0, 8'd0));
        step(1);
        expect_out("lost", 2'b10, 2'b01, 1'b0, 1'b1, lx(8'd0, 8'd1));
        step(6);
        cal_in[0] = 1'b1;
        step(3);
        expect_out("lost_10cyc", 2'b10, 2'b01, 1'b0, 1'b1, lx(8'd0, 8'd1));
        step(1);
        expect_out("recover", 2'b11, 2'b00, 1'b1, 1'b0, lx(8'd0, 8'd1));

        repeat (253) loss_event();
        step(5);
        expect_out("loss_254", 2'b11, 2'b00, 1'b1, 1'b0, lx(8'd0, 8'd254));
        repeat (47) loss_event();
        step(5);
        expect_out("loss_saturated", 2'b11, 2'b00, 1'b1, 1'b0, lx(8'd0, 8'd255));

        // rearm in the cycle sync_ok[0] rises
        cal_in[0] = 1'b0;
        step(4);
        expect_out("lost_pre_rearm", 2'b10, 2'b01, 1'b0, 1'b1, lx(8'd0, 8'd255));
        cal_in[0] = 1'b1;
        step(3);
        rearm = 2'b01;
        step(1);
        rearm = 2'b00;
        expect_out("rearm_wait", 2'b10, 2'b00, 1'b0, 1'b0, lx(8'd0, 8'd0));
        step(1);
        expect_out("rearm_pass", 2'b11, 2'b00, 1'b1, 1'b0, lx(8'd0, 8'd0));

        // async reset between edges
        step(2);
        #1;
        reset = 1'b1;
        expect_out("async_reset", 2'b00, 2'b00, 1'b0, 1'b0, lx(8'd0, 8'd0));
        step(2);
        expect_out("reset_held", 2'b00, 2'b00, 1'b0, 1'b0, lx(8'd0, 8'd0));
        cal_in = 2'b01;
        reset = 1'b0;
        step(3);
        expect_out("post_rst_edge3", 2'b00, 2'b00, 1'b0, 1'b0, lx(8'd0, 8'd0));
        step(1);
        expect_out("post_rst_pass", 2'b01, 2'b00, 1'b0, 1'b0, lx(8'd0, 8'd0));
        step(11);
        expect_out("post_rst_no_timeout", 2'b01, 2'b00, 1'b0, 1'b0, lx(8'd0, 8'd0));
        step(1);
        expect_out("post_rst_timeout", 2'b01, 2'b10, 1'b0, 1'b1, lx(8'd0, 8'd0));

        step(2);
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
